// File: rtl/io_timer_irq.sv
// io_timer_irq: prescaled 16-bit down-counter timer on the CPU IO bus with a level interrupt.
// Define IO_TIMER_CAPTURE_EN to add the synchronized capture_in pin and the CAPTURE register.
module io_timer_irq #(
  parameter logic [15:0] BASE = 16'h0100
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        interrupt_request,
  input  logic        capture_in
);

  typedef enum logic [2:0] {
    RegCtrl     = 3'd0,
    RegPrescale = 3'd1,
    RegReload   = 3'd2,
    RegCount    = 3'd3,
    RegStatus   = 3'd4,
    RegCapture  = 3'd5,
    RegRsvd6    = 3'd6,
    RegRsvd7    = 3'd7
  } reg_sel_e;

  reg_sel_e    reg_sel;
  logic        sel;
  logic        ctrl_wr, prescale_wr, reload_wr, count_wr, status_wr;

  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        irqen_q, irqen_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [15:0] presc_cnt_q, presc_cnt_d;
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;

  logic        tick, tick_eff, expire;
  logic        cap_flag;
  logic [15:0] capture_val;
  logic [15:0] rdata;

  logic        unused_addr0;
  assign unused_addr0 = io_addr[0];

  assign sel     = (io_addr[15:4] == BASE[15:4]);
  assign reg_sel = reg_sel_e'(io_addr[3:1]);

  always_comb begin
    ctrl_wr     = 1'b0;
    prescale_wr = 1'b0;
    reload_wr   = 1'b0;
    count_wr    = 1'b0;
    status_wr   = 1'b0;
    if (sel && io_wr) begin
      case (reg_sel)
        RegCtrl:     ctrl_wr     = 1'b1;
        RegPrescale: prescale_wr = 1'b1;
        RegReload:   reload_wr   = 1'b1;
        RegCount:    count_wr    = 1'b1;
        RegStatus:   status_wr   = 1'b1;
        default:     ;
      endcase
    end
  end

  // A tick is discarded when software overwrites COUNT or disables the timer in the same cycle.
  assign tick     = en_q && (presc_cnt_q == prescale_q);
  assign tick_eff = tick && !count_wr && !(ctrl_wr && !io_dout[0]);
  assign expire   = tick_eff && (count_q == 16'd0);

  always_comb begin
    en_d    = en_q;
    auto_d  = auto_q;
    irqen_d = irqen_q;
    if (ctrl_wr) begin
      en_d    = io_dout[0];
      auto_d  = io_dout[1];
      irqen_d = io_dout[2];
    end else if (expire && !auto_q) begin
      en_d = 1'b0;
    end

    prescale_d = prescale_wr ? io_dout : prescale_q;
    reload_d   = reload_wr ? io_dout : reload_q;

    presc_cnt_d = presc_cnt_q;
    if (ctrl_wr && io_dout[0] && !en_q) begin
      presc_cnt_d = 16'd0;
    end else if (en_q) begin
      presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
    end

    count_d = count_q;
    if (count_wr) begin
      count_d = io_dout;
    end else if (tick_eff) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else if (auto_q) begin
        count_d = reload_q;
      end
    end

    // Hardware set takes priority over a coincident write-1-to-clear.
    pend_d = expire | (pend_q & ~(status_wr & io_dout[0]));
    ovr_d  = (expire & pend_q) | (ovr_q & ~(status_wr & io_dout[1]));
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      en_q        <= 1'b0;
      auto_q      <= 1'b0;
      irqen_q     <= 1'b0;
      prescale_q  <= 16'd0;
      reload_q    <= 16'd0;
      count_q     <= 16'd0;
      presc_cnt_q <= 16'd0;
      pend_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      en_q        <= en_d;
      auto_q      <= auto_d;
      irqen_q     <= irqen_d;
      prescale_q  <= prescale_d;
      reload_q    <= reload_d;
      count_q     <= count_d;
      presc_cnt_q <= presc_cnt_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
    end
  end

`ifdef IO_TIMER_CAPTURE_EN
  // sync_q[1:0] is the two-flop synchronizer; sync_q[2] remembers the previous synced level.
  logic [2:0]  sync_q, sync_d;
  logic        cap_q, cap_d;
  logic [15:0] capture_q, capture_d;
  logic        cap_edge;

  assign cap_edge = sync_q[1] & ~sync_q[2];

  always_comb begin
    sync_d    = {sync_q[1:0], capture_in};
    capture_d = cap_edge ? count_q : capture_q;
    cap_d     = cap_edge | (cap_q & ~(status_wr & io_dout[2]));
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sync_q    <= 3'd0;
      cap_q     <= 1'b0;
      capture_q <= 16'd0;
    end else begin
      sync_q    <= sync_d;
      cap_q     <= cap_d;
      capture_q <= capture_d;
    end
  end

  assign cap_flag    = cap_q;
  assign capture_val = capture_q;
`else
  logic unused_capture;
  assign unused_capture = capture_in;
  assign cap_flag       = 1'b0;
  assign capture_val    = 16'd0;
`endif

  always_comb begin
    rdata = 16'd0;
    case (reg_sel)
      RegCtrl:     rdata = {13'd0, irqen_q, auto_q, en_q};
      RegPrescale: rdata = prescale_q;
      RegReload:   rdata = reload_q;
      RegCount:    rdata = count_q;
      RegStatus:   rdata = {13'd0, cap_flag, ovr_q, pend_q};
      RegCapture:  rdata = capture_val;
      default:     rdata = 16'd0;
    endcase
  end

  // Zero when not reading this block so several peripherals can be ORed onto the bus.
  assign io_din            = (io_rd && sel) ? rdata : 16'd0;
  assign interrupt_request = irqen_q & (pend_q | cap_flag);

endmodule

// File: tb/tb_io_timer_irq.sv
// Self-checking bench for io_timer_irq: register vector table, directed timing sequences and
// randomized timer runs checked against an arithmetic model. Honours IO_TIMER_CAPTURE_EN.
module tb_io_timer_irq;

  localparam logic [15:0] Base = 16'h0100;

  logic        clk = 1'b0;
  logic        resetq;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] io_din;
  logic        interrupt_request;
  logic        capture_in;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  io_timer_irq #(.BASE(Base)) dut (
    .clk              (clk),
    .resetq           (resetq),
    .io_rd            (io_rd),
    .io_wr            (io_wr),
    .io_addr          (io_addr),
    .io_dout          (io_dout),
    .io_din           (io_din),
    .interrupt_request(interrupt_request),
    .capture_in       (capture_in)
  );

  typedef struct {
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic [15:0] raddr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    io_addr = addr;
    io_dout = data;
    io_wr   = 1'b1;
    @(posedge clk);
    #1 io_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] addr, output logic [15:0] data);
    io_addr = addr;
    io_rd   = 1'b1;
    #1 data = io_din;
    io_rd   = 1'b0;
  endtask

  task automatic do_reset();
    io_rd      = 1'b0;
    io_wr      = 1'b0;
    io_addr    = 16'h0;
    io_dout    = 16'h0;
    capture_in = 1'b0;
    resetq     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetq = 1'b1;
  endtask

  // Counts rising edges until the STATUS bit reads 1; gives up after budget edges.
  task automatic wait_status(input int bitn, input int budget, output int n);
    logic [15:0] s;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      rd(Base + 16'h8, s);
    end while (!s[bitn] && n < budget);
  endtask

  // Timer state t edges after the enabling CTRL write, from tick and period arithmetic.
  function automatic void model(input int p, input int c, input int r, input bit au, input int t,
                                output int cnt, output bit en, output bit pend, output bit ovr);
    int k, kk, nexp;
    k = t / (p + 1);
    if (k <= c) begin
      cnt = c - k; en = 1'b1; pend = 1'b0; ovr = 1'b0;
    end else if (!au) begin
      cnt = 0; en = 1'b0; pend = 1'b1; ovr = 1'b0;
    end else begin
      kk   = k - c - 1;
      cnt  = r - (kk % (r + 1));
      nexp = 1 + kk / (r + 1);
      en   = 1'b1; pend = 1'b1; ovr = (nexp >= 2);
    end
  endfunction

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    logic [15:0] d, c0, expv;
    int n, p, c, r, t, dstep, mcnt;
    bit au, ie, men, mpend, movr;

    vecs[0] = '{Base + 16'h2, 16'hABCD, Base + 16'h2, 16'hABCD};
    vecs[1] = '{Base + 16'h4, 16'h1234, Base + 16'h4, 16'h1234};
    vecs[2] = '{Base + 16'h6, 16'hBEEF, Base + 16'h6, 16'hBEEF};
    vecs[3] = '{Base + 16'h0, 16'hFFFE, Base + 16'h0, 16'h0006};
    vecs[4] = '{Base + 16'h8, 16'hFFFF, Base + 16'h8, 16'h0000};
    vecs[5] = '{Base + 16'hA, 16'h5A5A, Base + 16'hA, 16'h0000};
    vecs[6] = '{Base + 16'hC, 16'hFFFF, Base + 16'hC, 16'h0000};
    vecs[7] = '{16'h0204,     16'h5555, Base + 16'h4, 16'h1234};
    vecs[8] = '{Base + 16'h3, 16'h0042, Base + 16'h2, 16'h0042};
    vecs[9] = '{Base + 16'h0, 16'h0000, Base + 16'h0, 16'h0000};

    // Reset state
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rd(Base + 16'(2 * i), d);
      check($sformatf("reset_reg%0d", i), d, 16'h0);
    end
    check("reset_irq", {15'd0, interrupt_request}, 16'h0);

    // Register read/write table
    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, d);
      check($sformatf("vec%0d", i), d, vecs[i].exp);
    end

    // Auto-reload period and overrun handling
    do_reset();
    wr(Base + 16'h2, 16'd3);
    wr(Base + 16'h4, 16'd4);
    wr(Base + 16'h6, 16'd4);
    wr(Base + 16'h0, 16'h7);
    wait_status(0, 40, n);
    check("period_first", 16'(n), 16'd20);
    check("period_irq", {15'd0, interrupt_request}, 16'd1);
    rd(Base + 16'h6, d);
    check("period_reload", d, 16'd4);
    wait_status(1, 40, n);
    check("period_second", 16'(n), 16'd20);
    rd(Base + 16'h8, d);
    check("ovr_status", d, 16'h3);
    wr(Base + 16'h8, 16'h1);
    rd(Base + 16'h8, d);
    check("clr_pend_status", d, 16'h2);
    check("clr_pend_irq", {15'd0, interrupt_request}, 16'd0);
    wr(Base + 16'h8, 16'h2);
    rd(Base + 16'h8, d);
    check("clr_ovr_status", d, 16'h0);

    // One-shot
    do_reset();
    wr(Base + 16'h6, 16'd2);
    wr(Base + 16'h0, 16'h1);
    wait_status(0, 20, n);
    check("oneshot_time", 16'(n), 16'd3);
    rd(Base + 16'h0, d);
    check("oneshot_ctrl", d, 16'h0);
    rd(Base + 16'h6, d);
    check("oneshot_count", d, 16'h0);
    repeat (10) @(posedge clk);
    #1;
    rd(Base + 16'h8, d);
    check("oneshot_no_ovr", d, 16'h1);
    rd(Base + 16'h6, d);
    check("oneshot_hold", d, 16'h0);

    // Write-1-clear coinciding with expiry; COUNT and CTRL writes on tick cycles
    do_reset();
    wr(Base + 16'h6, 16'd2);
    wr(Base + 16'h4, 16'd3);
    wr(Base + 16'h0, 16'h3);
    repeat (6) @(posedge clk);
    wr(Base + 16'h8, 16'h1);
    rd(Base + 16'h8, d);
    check("w1c_vs_set", d, 16'h3);
    wr(Base + 16'h6, 16'h1234);
    rd(Base + 16'h6, d);
    check("count_wr_on_tick", d, 16'h1234);
    wr(Base + 16'h0, 16'h2);
    rd(Base + 16'h6, d);
    check("disable_on_tick", d, 16'h1234);
    repeat (5) @(posedge clk);
    #1;
    rd(Base + 16'h6, d);
    check("disabled_hold", d, 16'h1234);

    // Decode and mid-count reset
    do_reset();
    wr(Base + 16'h2, 16'd1);
    wr(Base + 16'h4, 16'd50);
    wr(Base + 16'h6, 16'd2);
    wr(Base + 16'h0, 16'h7);
    wait_status(0, 20, n);
    check("irq_before_reset", {15'd0, interrupt_request}, 16'd1);
    rd(16'h0206, d);
    check("wrong_base", d, 16'h0);
    rd(Base + 16'hC, d);
    check("reserved_rd", d, 16'h0);
    io_addr = Base + 16'h8;
    #1;
    check("no_rd_strobe", io_din, 16'h0);
    repeat (3) @(posedge clk);
    #2 resetq = 1'b0;
    #1;
    rd(Base + 16'h6, d);
    check("rst_count", d, 16'h0);
    rd(Base + 16'h8, d);
    check("rst_status", d, 16'h0);
    rd(Base + 16'h0, d);
    check("rst_ctrl", d, 16'h0);
    check("rst_irq", {15'd0, interrupt_request}, 16'd0);
    @(negedge clk);
    resetq = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    rd(Base + 16'h8, d);
    check("post_rst_status", d, 16'h0);
    rd(Base + 16'h6, d);
    check("post_rst_count", d, 16'h0);

    // Capture
    do_reset();
    wr(Base + 16'h6, 16'd100);
    wr(Base + 16'h0, 16'h5);
    repeat (5) @(posedge clk);
    #1;
    rd(Base + 16'h6, c0);
    capture_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
`ifdef IO_TIMER_CAPTURE_EN
    rd(Base + 16'hA, d);
    expv = (d == c0 - 16'd3) ? c0 - 16'd3 : c0 - 16'd2;
    check("capture_value", d, expv);
    rd(Base + 16'h8, d);
    check("capture_cap", d, 16'h4);
    check("capture_irq", {15'd0, interrupt_request}, 16'd1);
    wr(Base + 16'h8, 16'h4);
    rd(Base + 16'h8, d);
    check("capture_clr", d, 16'h0);
`else
    rd(Base + 16'hA, d);
    check("capture_off_value", d, 16'h0);
    rd(Base + 16'h8, d);
    check("capture_off_cap", d, 16'h0);
    check("capture_off_irq", {15'd0, interrupt_request}, 16'd0);
`endif
    capture_in = 1'b0;

    // Randomized runs against the arithmetic model
    for (int tr = 0; tr < 12; tr++) begin
      do_reset();
      p  = $urandom_range(0, 3);
      c  = $urandom_range(0, 6);
      r  = $urandom_range(0, 6);
      au = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      wr(Base + 16'h2, 16'(p));
      wr(Base + 16'h4, 16'(r));
      wr(Base + 16'h6, 16'(c));
      wr(Base + 16'h0, {13'd0, ie, au, 1'b1});
      t = 0;
      for (int s = 0; s < 8; s++) begin
        dstep = $urandom_range(1, 12);
        repeat (dstep) @(posedge clk);
        #1;
        t += dstep;
        model(p, c, r, au, t, mcnt, men, mpend, movr);
        rd(Base + 16'h6, d);
        check($sformatf("rnd%0d_count_t%0d", tr, t), d, 16'(mcnt));
        rd(Base + 16'h8, d);
        check($sformatf("rnd%0d_status_t%0d", tr, t), d, {14'd0, movr, mpend});
        rd(Base + 16'h0, d);
        check($sformatf("rnd%0d_ctrl_t%0d", tr, t), d, {13'd0, ie, au, men});
        check($sformatf("rnd%0d_irq_t%0d", tr, t), {15'd0, interrupt_request},
              {15'd0, ie & mpend});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
